dcache_controller: RTL and testbench

DCACHE_CONTROLLER -- requirements
Module: dcache_controller

---
 rtl/dcache_pkg.sv | 18 +
 rtl/dcache_controller_if.sv | 31 +++
 rtl/dcache_word_sel.sv | 21 ++
 rtl/dcache_controller.sv | 148 ++++++++++++++
 tb/tb_dcache_controller.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_pkg.sv
// Shared widths and FSM encoding for the direct-mapped write-back data cache.
package dcache_pkg;
    localparam int TAG_W           = 3;
    localparam int IDX_W           = 3;
    localparam int OFF_W           = 2;
    localparam int ADDR_W          = TAG_W + IDX_W + OFF_W;
    localparam int MEM_ADDR_W      = TAG_W + IDX_W;
    localparam int WORDS_PER_BLOCK = 1 << OFF_W;
    localparam int DEF_WORD_W      = 8;
    localparam int BLOCK_W         = WORDS_PER_BLOCK * DEF_WORD_W;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WRITE_BACK = 2'd1,
        ST_MEM_READ   = 2'd2,
        ST_UPDATE     = 2'd3
    } state_e;
endpackage

// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side bus of the data cache; slave = cache, master = CPU/memory.
interface dcache_controller_if
    import dcache_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) ();
    localparam int BLK_W = WORDS_PER_BLOCK * WORD_W;

    logic                  read;
    logic                  write;
    logic [ADDR_W-1:0]     address;
    logic [WORD_W-1:0]     writedata;
    logic [WORD_W-1:0]     readdata;
    logic                  busywait;
    logic                  mem_read;
    logic                  mem_write;
    logic [MEM_ADDR_W-1:0] mem_address;
    logic [BLK_W-1:0]      mem_writedata;
    logic [BLK_W-1:0]      mem_readdata;
    logic                  mem_busywait;

    modport slave (
        input  read, write, address, writedata, mem_readdata, mem_busywait,
        output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

    modport master (
        output read, write, address, writedata, mem_readdata, mem_busywait,
        input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );
endinterface

// File: rtl/dcache_word_sel.sv
// Picks one word out of a cache block by byte offset; word0 lives in the low bits.
module dcache_word_sel
    import dcache_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic [WORDS_PER_BLOCK*WORD_W-1:0] block,
    input  logic [OFF_W-1:0]                  offset,
    output logic [WORD_W-1:0]                 word
);
    always_comb begin
        word = block[WORD_W-1:0];
        case (offset)
            2'd0: word = block[0*WORD_W +: WORD_W];
            2'd1: word = block[1*WORD_W +: WORD_W];
            2'd2: word = block[2*WORD_W +: WORD_W];
            2'd3: word = block[3*WORD_W +: WORD_W];
            default: word = block[WORD_W-1:0];
        endcase
    end
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache: combinational hit/read path, write-allocate
// miss handling through WRITE_BACK -> MEM_READ -> UPDATE.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int NUM_SETS = 8,
    parameter int WORD_W   = DEF_WORD_W
) (
    input logic                clock,
    input logic                reset,
    dcache_controller_if.slave bus
);
    localparam int BLK_W = WORDS_PER_BLOCK * WORD_W;

    state_e                state_q, state_d;
    logic [NUM_SETS-1:0]   valid_q, valid_d;
    logic [NUM_SETS-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]      tag_q  [NUM_SETS];
    logic [TAG_W-1:0]      tag_d  [NUM_SETS];
    logic [BLK_W-1:0]      data_q [NUM_SETS];
    logic [BLK_W-1:0]      data_d [NUM_SETS];

    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [BLK_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic [BLK_W-1:0]      fill_q, fill_d;
    logic [TAG_W-1:0]      miss_tag_q, miss_tag_d;
    logic [IDX_W-1:0]      miss_idx_q, miss_idx_d;

    logic [TAG_W-1:0]      addr_tag;
    logic [IDX_W-1:0]      addr_idx;
    logic [OFF_W-1:0]      addr_off;
    logic                  req;
    logic                  hit;
    logic                  busy_raw;

    assign addr_tag = bus.address[ADDR_W-1 -: TAG_W];
    assign addr_idx = bus.address[OFF_W +: IDX_W];
    assign addr_off = bus.address[OFF_W-1:0];
    assign req      = bus.read | bus.write;
    assign hit      = valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);

    dcache_word_sel #(.WORD_W(WORD_W)) u_word_sel (
        .block  (data_q[addr_idx]),
        .offset (addr_off),
        .word   (bus.readdata)
    );

    // Gating with reset keeps the CPU unstalled while reset is held, even with a request up.
    assign busy_raw      = (state_q == ST_IDLE) ? (req & ~hit) : 1'b1;
    assign bus.busywait      = reset & busy_raw;
    assign bus.mem_read      = mem_read_q;
    assign bus.mem_write     = mem_write_q;
    assign bus.mem_address   = mem_addr_q;
    assign bus.mem_writedata = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        tag_d       = tag_q;
        data_d      = data_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fill_d      = fill_q;
        miss_tag_d  = miss_tag_q;
        miss_idx_d  = miss_idx_q;

        case (state_q)
            ST_IDLE: begin
                if (req && !hit) begin
                    // Latch the missing line so the fill survives the CPU dropping its request.
                    miss_tag_d = addr_tag;
                    miss_idx_d = addr_idx;
                    if (valid_q[addr_idx] && dirty_q[addr_idx]) begin
                        state_d     = ST_WRITE_BACK;
                        mem_write_d = 1'b1;
                        mem_addr_d  = {tag_q[addr_idx], addr_idx};
                        mem_wdata_d = data_q[addr_idx];
                    end else begin
                        state_d    = ST_MEM_READ;
                        mem_read_d = 1'b1;
                        mem_addr_d = {addr_tag, addr_idx};
                    end
                end else if (bus.write && hit) begin
                    data_d[addr_idx][int'(addr_off)*WORD_W +: WORD_W] = bus.writedata;
                    dirty_d[addr_idx] = 1'b1;
                end
            end
            ST_WRITE_BACK: begin
                if (!bus.mem_busywait) begin
                    state_d     = ST_MEM_READ;
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = {miss_tag_q, miss_idx_q};
                end
            end
            ST_MEM_READ: begin
                if (!bus.mem_busywait) begin
                    state_d    = ST_UPDATE;
                    mem_read_d = 1'b0;
                    fill_d     = bus.mem_readdata;
                end
            end
            ST_UPDATE: begin
                data_d[miss_idx_q]  = fill_q;
                tag_d[miss_idx_q]   = miss_tag_q;
                valid_d[miss_idx_q] = 1'b1;
                dirty_d[miss_idx_q] = 1'b0;
                state_d             = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            miss_tag_q  <= '0;
            miss_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            miss_tag_q  <= miss_tag_d;
            miss_idx_q  <= miss_idx_d;
        end
    end

    // Tag and data storage is qualified by valid, so it carries no reset.
    always_ff @(posedge clock) begin
        tag_q       <= tag_d;
        data_q      <= data_d;
        mem_wdata_q <= mem_wdata_d;
        fill_q      <= fill_d;
    end
endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller with a fixed-latency block memory model.
module tb_dcache_controller;
    import dcache_pkg::*;

    localparam int WORD_W  = 8;
    localparam int MEM_LAT = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dcache_controller_if #(.WORD_W(WORD_W)) bus ();

    dcache_controller #(.NUM_SETS(8), .WORD_W(WORD_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        is_write;
        logic [5:0]  addr;
        logic [31:0] wdata;
    } mem_req_t;

    mem_req_t    req_log [$];
    logic [7:0]  exp_q   [$];
    logic [31:0] mem_blk [64];
    logic        mem_done = 1'b0;
    int          mem_cnt  = 0;
    logic [1:0]  last_op  = 2'b00;
    logic        both_seen = 1'b0;
    logic        saw_update;
    int          n_cmp = 0;
    int          n_err = 0;

    assign bus.mem_busywait = (bus.mem_read | bus.mem_write) & ~mem_done;

    // Memory: a new request (or change of request kind) restarts the latency count.
    always @(negedge clock) begin
        logic [1:0] op;
        mem_req_t   r;
        op = {bus.mem_read, bus.mem_write};
        if (op == 2'b11) both_seen = 1'b1;
        if (op == 2'b00 || op != last_op) begin
            mem_cnt  = 0;
            mem_done = 1'b0;
            if (op != 2'b00) begin
                r.is_write = bus.mem_write;
                r.addr     = bus.mem_address;
                r.wdata    = bus.mem_writedata;
                req_log.push_back(r);
            end
        end else if (!mem_done) begin
            mem_cnt++;
            if (mem_cnt >= MEM_LAT) begin
                mem_done = 1'b1;
                if (bus.mem_write) mem_blk[bus.mem_address] = bus.mem_writedata;
                else bus.mem_readdata = mem_blk[bus.mem_address];
            end
        end
        last_op = op;
    end

    task automatic cpu_access(input logic rd, input logic wr, input logic [7:0] addr,
                              input logic [7:0] wd, output int cycles,
                              output logic [7:0] rdata, output logic timed_out);
        bus.read = rd; bus.write = wr; bus.address = addr; bus.writedata = wd;
        cycles = 0; timed_out = 1'b0; saw_update = 1'b0;
        #1;
        while (bus.busywait !== 1'b0 && !timed_out) begin
            @(negedge clock); #1;
            cycles++;
            if (dut.state_q == ST_UPDATE) saw_update = 1'b1;
            if (cycles > 40) timed_out = 1'b1;
        end
        rdata = bus.readdata;
        @(negedge clock);
        bus.read = 1'b0; bus.write = 1'b0;
    endtask

    task automatic test_reset();
        bus.read = 0; bus.write = 0; bus.address = 0; bus.writedata = 0; bus.mem_readdata = 0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++; if (bus.busywait !== 1'b0) begin n_err++; $display("FAIL rst_busywait: got %b want 0", bus.busywait); end
        n_cmp++; if (bus.mem_read !== 1'b0) begin n_err++; $display("FAIL rst_mem_read: got %b want 0", bus.mem_read); end
        n_cmp++; if (bus.mem_write !== 1'b0) begin n_err++; $display("FAIL rst_mem_write: got %b want 0", bus.mem_write); end
        n_cmp++; if (dut.valid_q !== 8'h00) begin n_err++; $display("FAIL rst_valid: got %h want 00", dut.valid_q); end
        n_cmp++; if (dut.dirty_q !== 8'h00) begin n_err++; $display("FAIL rst_dirty: got %h want 00", dut.dirty_q); end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_read_miss();
        int cyc; logic [7:0] rd; logic to; mem_req_t r;
        req_log.delete();
        exp_q.push_back(8'h11);
        cpu_access(1, 0, 8'h00, 8'h00, cyc, rd, to);
        n_cmp++; if (to || cyc != MEM_LAT + 3) begin n_err++; $display("FAIL miss_latency: got %0d want %0d", cyc, MEM_LAT + 3); end
        n_cmp++; if (!saw_update) begin n_err++; $display("FAIL miss_update_state: got 0 want 1"); end
        n_cmp++; if (rd !== exp_q[0]) begin n_err++; $display("FAIL miss_readdata: got %h want %h", rd, exp_q[0]); end
        void'(exp_q.pop_front());
        n_cmp++;
        if (req_log.size() != 1) begin n_err++; $display("FAIL miss_mem_reqs: got %0d want 1", req_log.size()); end
        else begin
            r = req_log.pop_front();
            if (r.is_write !== 1'b0 || r.addr !== 6'h00) begin
                n_err++; $display("FAIL miss_mem_req: got w=%b a=%h want w=0 a=00", r.is_write, r.addr);
            end
        end
    endtask

    task automatic test_read_hit();
        int cyc; logic [7:0] rd; logic to;
        req_log.delete();
        exp_q.push_back(8'h44);
        cpu_access(1, 0, 8'h03, 8'h00, cyc, rd, to);
        n_cmp++; if (cyc != 0) begin n_err++; $display("FAIL hit_busywait_cycles: got %0d want 0", cyc); end
        n_cmp++; if (rd !== exp_q[0]) begin n_err++; $display("FAIL hit_readdata: got %h want %h", rd, exp_q[0]); end
        void'(exp_q.pop_front());
        n_cmp++; if (req_log.size() != 0) begin n_err++; $display("FAIL hit_mem_reqs: got %0d want 0", req_log.size()); end
    endtask

    task automatic test_write_hit();
        int cyc; logic [7:0] rd; logic to;
        req_log.delete();
        cpu_access(0, 1, 8'h01, 8'hAA, cyc, rd, to);
        n_cmp++; if (cyc != 0) begin n_err++; $display("FAIL wr_hit_cycles: got %0d want 0", cyc); end
        n_cmp++; if (dut.dirty_q[0] !== 1'b1) begin n_err++; $display("FAIL wr_hit_dirty: got %b want 1", dut.dirty_q[0]); end
        exp_q.push_back(8'hAA);
        cpu_access(1, 0, 8'h01, 8'h00, cyc, rd, to);
        n_cmp++; if (rd !== exp_q[0]) begin n_err++; $display("FAIL wr_hit_readback: got %h want %h", rd, exp_q[0]); end
        void'(exp_q.pop_front());
        n_cmp++; if (req_log.size() != 0) begin n_err++; $display("FAIL wr_hit_mem_reqs: got %0d want 0", req_log.size()); end
    endtask

    task automatic test_writeback();
        int cyc; logic [7:0] rd; logic to; mem_req_t r;
        req_log.delete();
        exp_q.push_back(8'h55);
        cpu_access(1, 0, 8'h20, 8'h00, cyc, rd, to);
        n_cmp++; if (to || cyc != 2 * (MEM_LAT + 1) + 2) begin n_err++; $display("FAIL wb_latency: got %0d want %0d", cyc, 2 * (MEM_LAT + 1) + 2); end
        n_cmp++; if (rd !== exp_q[0]) begin n_err++; $display("FAIL wb_readdata: got %h want %h", rd, exp_q[0]); end
        void'(exp_q.pop_front());
        n_cmp++;
        if (req_log.size() != 2) begin n_err++; $display("FAIL wb_mem_reqs: got %0d want 2", req_log.size()); end
        else begin
            r = req_log.pop_front();
            if (r.is_write !== 1'b1 || r.addr !== 6'h00 || r.wdata !== 32'h4433AA11) begin
                n_err++; $display("FAIL wb_victim: got w=%b a=%h d=%h want w=1 a=00 d=4433aa11", r.is_write, r.addr, r.wdata);
            end
            n_cmp++;
            r = req_log.pop_front();
            if (r.is_write !== 1'b0 || r.addr !== 6'h08) begin
                n_err++; $display("FAIL wb_refill: got w=%b a=%h want w=0 a=08", r.is_write, r.addr);
            end
        end
        n_cmp++; if (dut.dirty_q[0] !== 1'b0) begin n_err++; $display("FAIL wb_clean_after_fill: got %b want 0", dut.dirty_q[0]); end
    endtask

    task automatic test_reset_mid_miss();
        int cyc; logic [7:0] rd; logic to;
        bus.read = 1'b1; bus.address = 8'h00;
        @(negedge clock); #1;
        n_cmp++; if (bus.mem_read !== 1'b1) begin n_err++; $display("FAIL rmm_mem_read_before: got %b want 1", bus.mem_read); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (bus.mem_read !== 1'b0) begin n_err++; $display("FAIL rmm_mem_read: got %b want 0", bus.mem_read); end
        n_cmp++; if (bus.busywait !== 1'b0) begin n_err++; $display("FAIL rmm_busywait: got %b want 0", bus.busywait); end
        n_cmp++; if (dut.valid_q !== 8'h00) begin n_err++; $display("FAIL rmm_valid: got %h want 00", dut.valid_q); end
        bus.read = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        req_log.delete();
        exp_q.push_back(8'h11);
        cpu_access(1, 0, 8'h00, 8'h00, cyc, rd, to);
        n_cmp++; if (to || cyc != MEM_LAT + 3) begin n_err++; $display("FAIL rmm_remiss_latency: got %0d want %0d", cyc, MEM_LAT + 3); end
        n_cmp++; if (rd !== exp_q[0]) begin n_err++; $display("FAIL rmm_readdata: got %h want %h", rd, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_read_write_both();
        int cyc; logic [7:0] rd; logic to;
        req_log.delete();
        cpu_access(1, 1, 8'h02, 8'h5C, cyc, rd, to);
        n_cmp++; if (cyc != 0) begin n_err++; $display("FAIL rw_cycles: got %0d want 0", cyc); end
        exp_q.push_back(8'h5C);
        cpu_access(1, 0, 8'h02, 8'h00, cyc, rd, to);
        n_cmp++; if (rd !== exp_q[0]) begin n_err++; $display("FAIL rw_word2: got %h want %h", rd, exp_q[0]); end
        void'(exp_q.pop_front());
        n_cmp++; if (dut.dirty_q[0] !== 1'b1) begin n_err++; $display("FAIL rw_dirty: got %b want 1", dut.dirty_q[0]); end
        n_cmp++; if (req_log.size() != 0) begin n_err++; $display("FAIL rw_mem_reqs: got %0d want 0", req_log.size()); end
    endtask

    task automatic test_deassert_mid_miss();
        int cyc; logic [7:0] rd; logic to;
        req_log.delete();
        bus.write = 1'b1; bus.address = 8'h45; bus.writedata = 8'h77;
        repeat (2) @(negedge clock);
        bus.write = 1'b0;
        repeat (12) @(negedge clock);
        n_cmp++; if (dut.dirty_q[1] !== 1'b0) begin n_err++; $display("FAIL dmm_dirty: got %b want 0", dut.dirty_q[1]); end
        exp_q.push_back(8'hBB);
        cpu_access(1, 0, 8'h45, 8'h00, cyc, rd, to);
        n_cmp++; if (cyc != 0) begin n_err++; $display("FAIL dmm_hit_cycles: got %0d want 0", cyc); end
        n_cmp++; if (rd !== exp_q[0]) begin n_err++; $display("FAIL dmm_readdata: got %h want %h", rd, exp_q[0]); end
        void'(exp_q.pop_front());
        n_cmp++; if (req_log.size() != 1) begin n_err++; $display("FAIL dmm_mem_reqs: got %0d want 1", req_log.size()); end
    endtask

    task automatic test_back_to_back();
        int cyc; logic [7:0] rd; logic to; logic [7:0] exp; logic [7:0] addrs [8];
        addrs = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h44, 8'h45, 8'h46, 8'h47};
        exp_q = '{8'h11, 8'hAA, 8'h5C, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        req_log.delete();
        for (int i = 0; i < 8; i++) begin
            cpu_access(1, 0, addrs[i], 8'h00, cyc, rd, to);
            exp = exp_q.pop_front();
            n_cmp++;
            if (rd !== exp || cyc != 0) begin
                n_err++; $display("FAIL b2b_read_%h: got %h/%0d want %h/0", addrs[i], rd, cyc, exp);
            end
        end
        n_cmp++; if (req_log.size() != 0) begin n_err++; $display("FAIL b2b_mem_reqs: got %0d want 0", req_log.size()); end
    endtask

    task automatic test_mem_exclusive();
        n_cmp++; if (both_seen) begin n_err++; $display("FAIL mem_rw_exclusive: got both high want never"); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem_blk[i] = {4{i[7:0]}};
        mem_blk[0]  = 32'h44332211;
        mem_blk[8]  = 32'h88776655;
        mem_blk[17] = 32'hDDCCBBAA;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_writeback();
        test_reset_mid_miss();
        test_read_write_both();
        test_deassert_mid_miss();
        test_back_to_back();
        test_mem_exclusive();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
